// File: rtl/mult_share_arb_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_share_arb_pkg;

   // Sequencer states: waiting for a request, or running the engine.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Width of a requester index; never narrower than one bit.
   function automatic int id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Lowest bit of requester idx's operand inside a flat operand bus.
   function automatic int opnd_lsb(input int idx, input int w);
      return idx * w;
   endfunction

endpackage

// File: rtl/mult_share_arb_if.sv
// Request/grant/result bundle between client blocks and the shared multiplier.
// Latency: n/a (wires only).
// Backpressure: clients hold req until they see their gnt pulse.
interface mult_share_arb_if #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
);
   import mult_share_arb_pkg::*;

   localparam int IDW = id_w(NREQ);

   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] ina_flat;
   logic [NREQ*WIDTH-1:0] inb_flat;
   logic [NREQ-1:0]       gnt;
   logic                  busy;
   logic [2*WIDTH-1:0]    out;
   logic                  out_valid;
   logic [IDW-1:0]        out_id;

   // Client side: raises requests and operands, watches grants and results.
   modport master (
      output req, ina_flat, inb_flat,
      input  gnt, busy, out, out_valid, out_id
   );

   // Arbiter side.
   modport slave (
      input  req, ina_flat, inb_flat,
      output gnt, busy, out, out_valid, out_id
   );

endinterface

// File: rtl/mult_share_arb_core.sv
// Sequential shift-add unsigned multiplier, one partial product per clock.
// Latency: WIDTH clocks after load; done is high during the final step.
// Backpressure: none; load is only honoured, never refused, and restarts the engine.
module mult_core
   import mult_share_arb_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] w_acc_nxt;

   // Accumulator value after the current step; on the last step this is the product.
   assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign product   = w_acc_nxt;
   assign done      = (r_cnt == CW'(1));

   // Load operands, then shift/accumulate once per clock until the counter empties.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
      end else if (load) begin
         r_cnt    <= CW'(WIDTH);
         r_acc    <= '0;
         r_mcand  <= {{WIDTH{1'b0}}, a};
         r_mplier <= b;
      end else if (r_cnt != '0) begin
         r_acc    <= w_acc_nxt;
         r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
         r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
         r_cnt    <= r_cnt - CW'(1);
      end
   end

endmodule

// File: rtl/mult_share_arb.sv
// Shares one shift-add multiplier among NREQ requesters; MULT_SHARE_ARB_RR_EN selects round-robin, else fixed priority.
// Latency: gnt one cycle after acceptance, out_valid WIDTH edges after acceptance; one op per WIDTH+1 cycles.
// Backpressure: requests are only sampled in IDLE; a requester holds req until its gnt pulse.
module mult_share_arb
   import mult_share_arb_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
) (
   input  logic             clk,
   input  logic             rst,
   mult_share_arb_if.slave  bus
);

   localparam int IDW = id_w(NREQ);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [NREQ-1:0]    r_gnt;
   logic [NREQ-1:0]    w_gnt_nxt;
   logic               r_busy;
   logic               w_busy_nxt;
   logic [2*WIDTH-1:0] r_out;
   logic [2*WIDTH-1:0] w_out_nxt;
   logic               r_out_valid;
   logic               w_out_valid_nxt;
   logic [IDW-1:0]     r_out_id;
   logic [IDW-1:0]     w_out_id_nxt;
   logic [IDW-1:0]     r_owner;
   logic [IDW-1:0]     w_owner_nxt;

   logic               w_any;
   logic               w_found;
   logic [IDW-1:0]     w_win;
   logic               w_load;
   logic [WIDTH-1:0]   w_a;
   logic [WIDTH-1:0]   w_b;
   logic               w_done;
   logic [2*WIDTH-1:0] w_product;

   assign w_any = |bus.req;

`ifdef MULT_SHARE_ARB_RR_EN
   logic [IDW-1:0]     r_ptr;
   logic [2*NREQ-1:0]  w_dbl;
   logic [NREQ-1:0]    w_rot;
   int                 w_sum;

   // Round-robin pick: rotate requests so the pointer sits at bit 0, take the lowest set bit.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_sum   = 0;
      w_dbl   = {bus.req, bus.req} >> r_ptr;
      w_rot   = w_dbl[NREQ-1:0];
      for (int k = 0; k < NREQ; k++) begin
         if (!w_found && w_rot[k]) begin
            w_found = 1'b1;
            w_sum   = int'(r_ptr) + k;
            if (w_sum >= NREQ) begin
               w_sum = w_sum - NREQ;
            end
            w_win = IDW'(w_sum);
         end
      end
   end

   // Pointer moves one past the requester just granted.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (w_load) begin
         r_ptr <= (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;
      end
   end
`else
   // Fixed priority pick: lowest requesting index wins.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!w_found && bus.req[k]) begin
            w_found = 1'b1;
            w_win   = IDW'(k);
         end
      end
   end
`endif

   // Route the winner's operand pair to the engine.
   always_comb begin
      w_a = '0;
      w_b = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (w_win == IDW'(k)) begin
            w_a = bus.ina_flat[opnd_lsb(k, WIDTH) +: WIDTH];
            w_b = bus.inb_flat[opnd_lsb(k, WIDTH) +: WIDTH];
         end
      end
   end

   // Next-state and next-output logic for the IDLE/RUN sequencer.
   always_comb begin
      w_state_nxt     = r_state;
      w_gnt_nxt       = '0;
      w_busy_nxt      = r_busy;
      w_out_nxt       = r_out;
      w_out_valid_nxt = 1'b0;
      w_out_id_nxt    = r_out_id;
      w_owner_nxt     = r_owner;
      w_load          = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_load      = 1'b1;
               w_gnt_nxt   = NREQ'(1) << w_win;
               w_owner_nxt = w_win;
               w_busy_nxt  = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_done) begin
               w_out_nxt       = w_product;
               w_out_id_nxt    = r_owner;
               w_out_valid_nxt = 1'b1;
               w_busy_nxt      = 1'b0;
               w_state_nxt     = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset drops any in-flight operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_gnt       <= '0;
         r_busy      <= 1'b0;
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_out_id    <= '0;
         r_owner     <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_gnt       <= w_gnt_nxt;
         r_busy      <= w_busy_nxt;
         r_out       <= w_out_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_out_id    <= w_out_id_nxt;
         r_owner     <= w_owner_nxt;
      end
   end

   mult_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .load    (w_load),
      .a       (w_a),
      .b       (w_b),
      .done    (w_done),
      .product (w_product)
   );

   assign bus.gnt       = r_gnt;
   assign bus.busy      = r_busy;
   assign bus.out       = r_out;
   assign bus.out_valid = r_out_valid;
   assign bus.out_id    = r_out_id;

endmodule
